// File: rtl/layer_pkg.sv
// ============================================================================
// Module   : layer_pkg
// Summary  : Shared types and helpers for the fixed-point streaming layers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_pkg;

    typedef enum logic {
        eIDLE = 1'b0,
        eEMIT = 1'b1
    } state_e;

    // Limits are returned as longint, so word widths up to 32 bits are supported.
    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

    // Unity gain in Qm.n format.
    function automatic longint default_gain(input int n_size);
        return longint'(1) << n_size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_sat_mult.sv
// ============================================================================
// Module   : fxp_sat_mult
// Summary  : Signed Qm.n multiply, arithmetic shift right by N_SIZE, saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_sat_mult
    import layer_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int N_SIZE    = 8
) (
    input  logic signed [WORD_SIZE-1:0] a_i,
    input  logic signed [WORD_SIZE-1:0] b_i,
    output logic signed [WORD_SIZE-1:0] data_o
);

    localparam int PW = 2 * WORD_SIZE;
    localparam logic signed [PW-1:0] MAX_V = PW'(sat_max(WORD_SIZE));
    localparam logic signed [PW-1:0] MIN_V = PW'(sat_min(WORD_SIZE));

    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;

    assign product = PW'(a_i) * PW'(b_i);
    // Arithmetic shift rounds toward negative infinity.
    assign shifted = product >>> N_SIZE;

    always_comb begin
        data_o = shifted[WORD_SIZE-1:0];
        if (shifted > MAX_V) begin
            data_o = MAX_V[WORD_SIZE-1:0];
        end else if (shifted < MIN_V) begin
            data_o = MIN_V[WORD_SIZE-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/gap_unpool_layer.sv
// ============================================================================
// Module   : gap_unpool_layer
// Summary  : Scales one input word by GAIN and broadcasts it OUTPUT_SIZE times.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gap_unpool_layer
    import layer_pkg::*;
#(
    parameter int                          OUTPUT_SIZE = 4,
    parameter int                          WORD_SIZE   = 16,
    parameter int                          N_SIZE      = 8,
    parameter logic signed [WORD_SIZE-1:0] GAIN        = WORD_SIZE'(default_gain(N_SIZE))
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    output logic                          ready_o,
    input  logic                          valid_i,
    input  logic signed [WORD_SIZE-1:0]   data_r_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic signed [WORD_SIZE-1:0]   data_r_o,
    output logic                          last_o
);

    localparam int                CNT_W    = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OUTPUT_SIZE - 1);

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic signed [WORD_SIZE-1:0]  data_q, data_d;
    logic signed [WORD_SIZE-1:0]  scaled;
    logic                         accept;
    logic                         handshake;

    fxp_sat_mult #(
        .WORD_SIZE (WORD_SIZE),
        .N_SIZE    (N_SIZE)
    ) u_mult (
        .a_i    (data_r_i),
        .b_i    (GAIN),
        .data_o (scaled)
    );

    assign valid_o   = (state_q == eEMIT);
    assign last_o    = valid_o && (count_q == LAST_CNT);
    // Reopening on the last handshake gives zero-bubble back-to-back bursts.
    assign ready_o   = (state_q == eIDLE) || (last_o && ready_i);
    assign accept    = valid_i && ready_o;
    assign handshake = valid_o && ready_i;
    assign data_r_o  = data_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;

        if (accept) begin
            data_d = scaled;
        end

        case (state_q)
            eIDLE: begin
                if (valid_i) begin
                    state_d = eEMIT;
                    count_d = '0;
                end
            end
            eEMIT: begin
                if (handshake) begin
                    if (!last_o) begin
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        count_d = '0;
                        state_d = valid_i ? eEMIT : eIDLE;
                    end
                end
            end
            default: begin
                state_d = eIDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/gap_unpool_layer.md
Name: gap_unpool_layer

Overview:
- Inverse of the global-average-pooling stage: one scaled word is broadcast back to a sequence of OUTPUT_SIZE words.
- Accepts one signed fixed-point word from the previous layer and multiplies it once by a Qm.n GAIN with saturation.
- Emits the result OUTPUT_SIZE times on a valid-ready stream, flagging the final word.
- Sits between a per-channel scalar producer and a sequential consumer expecting OUTPUT_SIZE samples.

Parameters:
- OUTPUT_SIZE, 4: number of output words per accepted input; must be >= 1.
- WORD_SIZE, 16: bit width of input and output words.
- N_SIZE, 8: fractional bits, Qm.n.
- GAIN, 2**N_SIZE (1.0): signed WORD_SIZE Qm.n scale applied to each input.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- ready_o  out  1  block can accept data_r_i this cycle.
- valid_i  in  1  previous layer has valid data.
- data_r_i  in  WORD_SIZE  signed input word, expected straight from a register.
- valid_o  out  1  data_r_o is valid.
- ready_i  in  1  next layer accepts data_r_o this cycle.
- data_r_o  out  WORD_SIZE  signed output word, driven directly from a register.
- last_o  out  1  high with valid_o on the OUTPUT_SIZE-th word of a burst.

Behaviour:
- Reset: one clock, synchronous, active-low (reset_n_i low at posedge clk_i).
  - Effects: state to eIDLE, count_r to 0, valid_o=0, last_o=0, ready_o=1.
  - data_r_o is cleared to 0.
  - Reset mid-burst abandons the remaining words; no word is emitted after reset.
- Counter: count_r width is max(1,$clog2(OUTPUT_SIZE)) and counts words emitted in the current burst.
- States and transitions:
  - eIDLE: ready_o=1, valid_o=0. valid_i=1 means accept; go to eEMIT, count_r=0.
  - eEMIT: valid_o=1. last_o=(count_r==OUTPUT_SIZE-1).
    - Handshake (valid_o&&ready_i) on a non-last word: count_r++.
    - Handshake on the last word with valid_i=1: accept the new word, stay in eEMIT, count_r=0 (zero-bubble back-to-back).
    - Handshake on the last word with valid_i=0: go to eIDLE, count_r=0.
    - No handshake: hold everything, including data_r_o, last_o and count_r.
  - ready_o = (state==eIDLE) | (state==eEMIT && last_o && ready_i). This makes the block a helpful producer and helpful consumer.
- Accept: en = valid_i && ready_o. On en, data_r_o <= sat_scale(data_r_i). Latency is 1 cycle: accepted at edge T, valid_o high from T+1.
- Arithmetic:
  - Form the 2*WORD_SIZE signed product data_r_i*GAIN.
  - Arithmetic shift right by N_SIZE (truncate toward -inf).
  - Saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - The product is computed once per input, never per output word.
- OUTPUT_SIZE=1: every output word has last_o=1. Sustained throughput is one word per cycle.
- A burst always lasts exactly OUTPUT_SIZE handshakes, regardless of how ready_i toggles.
- valid_o must never drop in eEMIT without a handshake. data_r_o must stay stable while valid_o=1 and ready_i=0.

Decomposition:
- Shared package (layer_pkg): state_e typedef {eIDLE, eEMIT}, plus helper functions for the saturation limits and the default GAIN computation.
- One sub-module, fxp_sat_mult. It is combinational with parameters WORD_SIZE and N_SIZE; inputs a_i, b_i; output data_o.
  - Function: multiply, shift, saturate.
  - It is reusable by other layers.
- Controller, counter and output register live in gap_unpool_layer.

Test Plan:
- Defaults, ready_i=1, one input 0x0180 → accepted at T; valid_o at T+1..T+4 with data_r_o=0x0180; last_o only at T+4; ready_o=1 at T+4; valid_o=0 at T+5.
- Back-to-back: valid_i held high with inputs 0x0100 then 0xFF00, ready_i=1 → 8 consecutive valid cycles (0x0100 ×4, 0xFF00 ×4), no bubble; second input accepted on the last-word cycle of the first burst.
- Backpressure: ready_i random at 50%, input 0x0040, GAIN=0x0080 → exactly 4 words of 0x0020; data_r_o and last_o stable through stalls; ready_o=0 until the last handshake.
- Saturation: GAIN=0x0200. Input 0x7000 → 0x7FFF. Input 0x9000 → 0x8000. Input 0xFFFF → 0xFFFE.
- Reset mid-burst: reset_n_i low for 1 cycle after 2 of 4 words → next cycle valid_o=0, last_o=0, data_r_o=0, ready_o=1; the next input produces a full 4-word burst.
- OUTPUT_SIZE=1, ready_i=1, 5 streamed inputs → 5 outputs on consecutive cycles, each with last_o=1.
